// File: rtl/controle_somador16.sv
// Nibble-serial add/subtract controller: one 4-bit ripple slice (four
// somadorcompleto cells) is sequenced over NIBBLES cycles to form a W-bit result.

module somadorcompleto (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module controle_somador16 #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 co,
  output logic                 ovf
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    SOMA   = 2'd1,
    FIM    = 2'd2
  } estado_t;

  estado_t         state_r;
  estado_t         state_s;
  logic [W-1:0]    opa_r;
  logic [W-1:0]    opb_r;
  logic [W-1:0]    result_r;
  logic            carry_r;
  logic            co_r;
  logic            ovf_r;
  logic [IW-1:0]   idx_r;

  logic [3:0]      nib_a_s;
  logic [3:0]      nib_b_s;
  logic [3:0]      sum_s;
  logic [4:0]      c_s;
  logic            last_s;

  // Subtraction arrives here already as a + ~b + 1, so the slice only ever adds.
  assign nib_a_s = opa_r[{idx_r, 2'b00} +: 4];
  assign nib_b_s = opb_r[{idx_r, 2'b00} +: 4];
  assign c_s[0]  = carry_r;
  assign last_s  = (idx_r == IW'(NIBBLES - 1));

  for (genvar i = 0; i < 4; i++) begin : g_slice
    somadorcompleto u_fa (
      .x   (nib_a_s[i]),
      .y   (nib_b_s[i]),
      .cin (c_s[i]),
      .s   (sum_s[i]),
      .cout(c_s[i+1])
    );
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      OCIOSO: begin
        if (start) state_s = SOMA;
        else       state_s = OCIOSO;
      end
      SOMA: begin
        if (last_s) state_s = FIM;
        else        state_s = SOMA;
      end
      FIM:     state_s = OCIOSO;
      default: state_s = OCIOSO;
    endcase
  end

  // State register and datapath: capture operands, then one nibble per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= OCIOSO;
      opa_r    <= {W{1'b0}};
      opb_r    <= {W{1'b0}};
      result_r <= {W{1'b0}};
      carry_r  <= 1'b0;
      co_r     <= 1'b0;
      ovf_r    <= 1'b0;
      idx_r    <= {IW{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        OCIOSO: begin
          if (start) begin
            opa_r    <= a;
            opb_r    <= sub ? ~b : b;
            carry_r  <= sub;
            idx_r    <= {IW{1'b0}};
            result_r <= {W{1'b0}};
            co_r     <= 1'b0;
            ovf_r    <= 1'b0;
          end
        end
        SOMA: begin
          result_r[{idx_r, 2'b00} +: 4] <= sum_s;
          carry_r <= c_s[4];
          idx_r   <= idx_r + IW'(1);
          if (last_s) begin
            co_r  <= c_s[4];
            ovf_r <= c_s[3] ^ c_s[4];
          end
        end
        FIM: begin
          idx_r <= idx_r;
        end
        default: begin
          idx_r <= {IW{1'b0}};
        end
      endcase
    end
  end

  assign ready  = (state_r == OCIOSO);
  assign busy   = (state_r == SOMA) || (state_r == FIM);
  assign done   = (state_r == FIM);
  assign result = result_r;
  assign co     = co_r;
  assign ovf    = ovf_r;

endmodule

// File: tb/tb_controle_somador16.sv
// Directed bench for controle_somador16 (NIBBLES=4): hand-computed vectors,
// latency, busy protection and asynchronous reset behaviour.

module tb_controle_somador16;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        co;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  controle_somador16 #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .result(result),
    .co    (co),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one operation, scramble the inputs afterwards, then check latency and outputs.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic sv, input logic [15:0] er, input logic eco, input logic eovf);
    int  n;
    bit  seen;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    a = av; b = bv; sub = sv; start = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = ~sv;
    seen = 1'b0;
    while (!seen && n < 12) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
    end
    chk({tag, "_lat"}, 32'(n), 32'd5);
    chk({tag, "_res"}, 32'(result), 32'(er));
    chk({tag, "_co"},  32'(co), 32'(eco));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    rst = 1'b0; start = 1'b0; sub = 1'b0; a = 16'h0000; b = 16'h0000;
    #2 rst = 1'b1;
    #1;
    chk("rst_ready",  32'(ready),  32'd1);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_result", 32'(result), 32'h0000);
    chk("rst_co",     32'(co),     32'd0);
    chk("rst_ovf",    32'(ovf),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovfadd", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub1",   16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub2",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Busy protection: start held high with new operands throughout.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    @(posedge clk);                       // E0
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF;
    dones = 0;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
      if (e == 4) chk("busy_res", 32'(result), 32'h3333);
      if (e == 4) chk("busy_done", 32'(done), 32'd1);
    end
    chk("busy_pulses", 32'(dones), 32'd1);
    chk("busy_e5_ready", 32'(ready), 32'd1);
    chk("busy_e5_busy",  32'(busy),  32'd0);
    @(posedge clk);                       // E6 accepts FFFF+FFFF
    @(negedge clk);
    start = 1'b0;
    chk("busy_e6_busy", 32'(busy), 32'd1);
    for (int e = 7; e <= 10; e++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("busy_next_done", 32'(done),   32'd1);
    chk("busy_next_res",  32'(result), 32'hFFFE);
    chk("busy_next_co",   32'(co),     32'd1);

    // Reset mid-operation at E2.
    @(negedge clk);
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(posedge clk);                       // E0
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);                       // E1
    @(posedge clk);                       // E2
    #1 rst = 1'b1;
    #1;
    chk("mid_result", 32'(result), 32'h0000);
    chk("mid_co",     32'(co),     32'd0);
    chk("mid_ready",  32'(ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("mid_no_done", 32'(dones), 32'd0);
    run_op("after", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
